rv32i_mem_adapter: RTL and testbench
====================================

Name: rv32i_mem_adapter

Overview:
- Sits directly downstream of the multicycle rv32i core's memory port and upstream of a word-wide synchronous-read RAM.
- Turns core byte-addressed requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word RAM accesses: sub-word loads are extracted and extended; sub-word stores use read-modify-write (RMW).
- Also decodes a small MMIO window containing an LED register and a free-running cycle counter.
- Handshakes with the core via valid/ready plus a one-cycle response pulse; the core holds its ena low until resp_valid.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window.
- LED_W, 8, LED register width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; **synchronous, active-low**.
- req_valid  in  1  core request present.
- req_ready  out  1  adapter can accept; high only in S_IDLE.
- req_addr  in  32  byte address.
- req_wr  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_wr_data  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  valid with resp_valid; misaligned or unmapped access.
- resp_rd_data  out  32  load result; 0 for stores and errors.
- ram_addr  out  $clog2(RAM_WORDS)  word index.
- ram_wr_ena  out  1  RAM write strobe.
- ram_wr_data  out  32  RAM write word.
- ram_rd_data  in  32  RAM data, valid one cycle after ram_addr is sampled.
- leds  out  LED_W  LED register.

Behaviour:
- All outputs are registered or decoded from state only; no combinational path from req_* to ram_* or resp_*.
- Reset (rst==0 at posedge):
  - state = S_IDLE.
  - req_ready = 1 after release.
  - resp_valid, resp_err, resp_rd_data, ram_wr_ena, ram_addr, ram_wr_data, leds, cycle counter all = 0.
- Reset mid-operation aborts the request. No RAM write occurs in any cycle where rst==0, and no response is ever issued for the aborted request.
- Acceptance: at a posedge with state==S_IDLE and req_valid==1, latch addr, wr, funct3, wr_data. req_valid outside S_IDLE is ignored; the core must hold the request.
- Error check, at acceptance:
  - Misaligned: halfword with addr[0]==1, or word with addr[1:0]!=0.
  - Unmapped: not below RAM_WORDS*4 and not within MMIO_BASE..MMIO_BASE+7.
  - Undefined funct3 is also an error.
  - On error: S_IDLE -> S_RESP with resp_err=1; no RAM or MMIO side effect.
- FSM:
  - S_IDLE -> S_ACCESS, or S_RESP on error.
  - S_ACCESS, which drives ram_addr = addr[ADDR_W+1:2]:
    - SW: ram_wr_ena=1, ram_wr_data = wr_data; -> S_RESP.
    - Load or SB/SH: read; -> S_WAIT.
    - MMIO: read/write performed here; -> S_RESP.
  - S_WAIT: ram_rd_data is valid.
    - Load: extract lane per addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU; latch; -> S_RESP.
    - SB/SH: form the merged word; -> S_MERGE.
  - S_MERGE: ram_wr_ena=1 with the merged word, same ram_addr; -> S_RESP.
  - S_RESP: resp_valid=1 for exactly one cycle; -> S_IDLE.
- Latency, counted as cycles from the acceptance edge to the resp_valid cycle:
  - SW or MMIO: 2.
  - Load: 3.
  - SB/SH: 4.
  - Error: 1.
- Throughput: back-to-back requests accepted on the cycle after resp_valid.
- Lanes are little-endian: byte k = word[8k+7:8k].
- MMIO:
  - +0: LED register, RW. Write stores wr_data[LED_W-1:0] (SB/SH/SW all write the low bits). Read returns the value zero-extended.
  - +4: cycle counter, RO. 32-bit, increments every non-reset cycle, wraps 0xFFFF_FFFF -> 0. Writes are ignored without error. Reads return the value at S_ACCESS.

Decomposition:
- Add to rv32i_defines.sv:
  - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants.
  - MMIO_LED_OFFSET and MMIO_CYCLES_OFFSET.
  - mem_adapter_state_t enum {S_IDLE, S_ACCESS, S_WAIT, S_MERGE, S_RESP}.
- Sub-module rv32i_byte_lane (combinational):
  - Inputs: addr[1:0], funct3, word_in, store_data.
  - Outputs: load_value (extended) and merged_word.
  - Bench it separately.

Test Plan:
- Preload word 0x80FF_7F01 at byte 0x10:
  - LB 0x13 -> 0xFFFF_FF80.
  - LBU 0x13 -> 0x0000_0080.
  - LH 0x12 -> 0xFFFF_80FF.
  - LHU 0x12 -> 0x0000_80FF.
  - LW 0x10 -> 0x80FF_7F01.
  - Each gives resp_valid exactly 3 cycles after acceptance and resp_err=0.
- Same preload, SB 0x11 with data 0x0000_00AA -> a single ram_wr_ena cycle writing 0x80FF_AA01 at word 4; resp_valid 4 cycles after acceptance. A following LW 0x10 returns 0x80FF_AA01.
- Misaligned SW to 0x15 and unmapped LW to 0x0000_1000 (RAM_WORDS=256) -> resp_err=1, resp_rd_data=0, resp_valid 1 cycle after acceptance, ram_wr_ena never asserted.
- SW 0xFFFF_0000 with data 0x1234_5678 -> leds=0x78. Two LWs of 0xFFFF_0004 accepted 7 cycles apart -> returned values differ by 7.
- Assert rst=0 while in S_WAIT of SH 0x12 -> no ram_wr_ena and no resp_valid; after release req_ready=1 and leds=0. An LW 0x10 then returns the unchanged word.
- req_valid held high through a pending load -> the second request is accepted on the cycle after resp_valid, never earlier.

Source files
------------

// File: rtl/rv32i_defines.sv
// Shared constants and types for the rv32i memory adapter: RV32I load/store
// funct3 encodings, MMIO register offsets and the adapter FSM state type.
package rv32i_defines;

    // Load encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Byte offsets of the MMIO registers inside the window
    localparam logic [31:0] MMIO_LED_OFFSET    = 32'h0000_0000;
    localparam logic [31:0] MMIO_CYCLES_OFFSET = 32'h0000_0004;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_MERGE  = 3'd3,
        S_RESP   = 3'd4
    } mem_adapter_state_t;

    // True when funct3 names a defined load (wr=0) or store (wr=1).
    function automatic logic funct3_legal(input logic wr, input logic [2:0] f3);
        if (wr) begin
            return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
        end
        return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
               (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
    endfunction

endpackage

// File: rtl/rv32i_byte_lane.sv
// Little-endian lane logic: extracts and extends a sub-word load from a RAM
// word, and merges sub-word store data into a RAM word for read-modify-write.
module rv32i_byte_lane
    import rv32i_defines::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_value,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes
    always_comb begin
        w_byte = i_word[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    // Sign- or zero-extend the selected lane for loads
    always_comb begin
        o_load_value = i_word;
        case (i_funct3)
            FUNCT3_LB:  o_load_value = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LH:  o_load_value = {{16{w_half[15]}}, w_half};
            FUNCT3_LBU: o_load_value = {24'd0, w_byte};
            FUNCT3_LHU: o_load_value = {16'd0, w_half};
            default:    o_load_value = i_word;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane
    always_comb begin
        o_merged_word = i_store_data;
        case (i_funct3)
            FUNCT3_SB: begin
                o_merged_word = i_word;
                o_merged_word[{i_addr, 3'b000} +: 8] = i_store_data[7:0];
            end
            FUNCT3_SH: begin
                o_merged_word = i_word;
                o_merged_word[{i_addr[1], 4'b0000} +: 16] = i_store_data[15:0];
            end
            default: o_merged_word = i_store_data;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_adapter.sv
// Bridges the rv32i core's byte-addressed memory port to a word-wide
// synchronous-read RAM, with an MMIO window holding an LED register and a
// free-running cycle counter.
//
// Handshake: a request is accepted at the rising edge where req_valid and
// req_ready are both high; req_ready is high only in S_IDLE, and the core
// holds its request stable until then. Exactly one resp_valid pulse follows
// each accepted request unless reset intervenes, in which case none does.
module rv32i_mem_adapter
    import rv32i_defines::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          LED_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_addr,
    input  logic                         req_wr,
    input  logic [2:0]                   req_funct3,
    input  logic [31:0]                  req_wr_data,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [31:0]                  resp_rd_data,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic                         ram_wr_ena,
    output logic [31:0]                  ram_wr_data,
    input  logic [31:0]                  ram_rd_data,
    output logic [LED_W-1:0]             leds,
    output logic [2:0]                   o_dbg_state
);

    localparam int          ADDR_W    = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    mem_adapter_state_t r_state;
    logic               r_wr;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic               r_is_mmio;
    logic               r_mmio_cyc;
    logic [31:0]        r_wr_data;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_wr_ena;
    logic [31:0]        r_ram_wr_data;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [31:0]        r_resp_rd_data;
    logic [LED_W-1:0]   r_leds;
    logic [31:0]        r_cycles;

    logic [31:0]        w_mmio_off;
    logic               w_in_ram;
    logic               w_in_mmio;
    logic               w_misaligned;
    logic               w_err;
    logic               w_is_sw;
    logic [31:0]        w_load_value;
    logic [31:0]        w_merged_word;

    // Classify the incoming request; only consumed at the acceptance edge
    always_comb begin
        w_mmio_off   = req_addr - MMIO_BASE;
        w_in_ram     = ({1'b0, req_addr} < RAM_BYTES);
        w_in_mmio    = (w_mmio_off < 32'd8);
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_err        = !funct3_legal(req_wr, req_funct3) || w_misaligned ||
                       !(w_in_ram || w_in_mmio);
        w_is_sw      = req_wr && (req_funct3 == FUNCT3_SW);
    end

    rv32i_byte_lane u_byte_lane (
        .i_addr        (r_lane),
        .i_funct3      (r_funct3),
        .i_word        (ram_rd_data),
        .i_store_data  (r_wr_data),
        .o_load_value  (w_load_value),
        .o_merged_word (w_merged_word)
    );

    // Request FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_wr           <= 1'b0;
            r_funct3       <= 3'd0;
            r_lane         <= 2'd0;
            r_is_mmio      <= 1'b0;
            r_mmio_cyc     <= 1'b0;
            r_wr_data      <= 32'd0;
            r_ram_addr     <= '0;
            r_ram_wr_ena   <= 1'b0;
            r_ram_wr_data  <= 32'd0;
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_rd_data <= 32'd0;
            r_leds         <= '0;
        end else begin
            r_ram_wr_ena <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wr          <= req_wr;
                        r_funct3      <= req_funct3;
                        r_lane        <= req_addr[1:0];
                        r_is_mmio     <= w_in_mmio;
                        r_mmio_cyc    <= w_mmio_off[2];
                        r_wr_data     <= req_wr_data;
                        r_ram_addr    <= req_addr[ADDR_W+1:2];
                        r_ram_wr_data <= req_wr_data;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state      <= S_ACCESS;
                            // Full-word RAM stores write straight away in S_ACCESS
                            r_ram_wr_ena <= w_is_sw && w_in_ram;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_is_mmio) begin
                        if (r_wr) begin
                            // Counter writes are silently dropped
                            if (!r_mmio_cyc) begin
                                r_leds <= r_wr_data[LED_W-1:0];
                            end
                        end else begin
                            r_resp_rd_data <= r_mmio_cyc ? r_cycles : 32'(r_leds);
                        end
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else if (r_wr && (r_funct3 == FUNCT3_SW)) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wr) begin
                        r_ram_wr_data <= w_merged_word;
                        r_ram_wr_ena  <= 1'b1;
                        r_state       <= S_MERGE;
                    end else begin
                        r_resp_rd_data <= w_load_value;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_MERGE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_err     <= 1'b0;
                    r_resp_rd_data <= 32'd0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycles <= 32'd0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // The write strobe is qualified by rst so an aborted request can never
    // commit to RAM in the cycle reset is asserted.
    assign ram_wr_ena   = r_ram_wr_ena & rst;
    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_rd_data = r_resp_rd_data;
    assign ram_addr     = r_ram_addr;
    assign ram_wr_data  = r_ram_wr_data;
    assign leds         = r_leds;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rv32i_mem_adapter.sv
// Directed bench for rv32i_mem_adapter with a behavioural synchronous RAM.
module tb_rv32i_mem_adapter;
    import rv32i_defines::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wr_data;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rd_data;
    logic [7:0]  ram_addr;
    logic        ram_wr_ena;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;
    logic [7:0]  leds;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] run_cnt = 32'd0;

    // exp entry: {counter_read, err, latency[7:0], data[31:0]}
    logic [41:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] cnt_q[$];
    logic [31:0] cval_q[$];
    int          last_resp_cyc = 0;
    int          wr_cnt = 0;
    logic [7:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [31:0] mem [256];

    rv32i_mem_adapter #(.RAM_WORDS(256), .MMIO_BASE(32'hFFFF_0000), .LED_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wr       (req_wr),
        .req_funct3   (req_funct3),
        .req_wr_data  (req_wr_data),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rd_data (resp_rd_data),
        .ram_addr     (ram_addr),
        .ram_wr_ena   (ram_wr_ena),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data),
        .leds         (leds),
        .o_dbg_state  (dbg_state)
    );

    // Clock, edge counter and reference cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) run_cnt = 32'd0;
        else      run_cnt = run_cnt + 32'd1;
    end

    // Synchronous-read RAM
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'h80FF_7F01;
        mem[8] = 32'h1122_3344;
    end

    always @(posedge clk) begin
        if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (ram_wr_ena) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = ram_addr;
            last_wr_data = ram_wr_data;
        end
    end

    // Response monitor / scoreboard
    always @(negedge clk) begin
        logic [41:0] e;
        logic [31:0] c;
        int          a;
        if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid expected=none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                c = cnt_q.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, e[40]});
                chk("resp_rd_data", resp_rd_data, e[41] ? c : e[31:0]);
                chk("resp_latency", 32'(cyc - a + 1), {24'd0, e[39:32]});
                if (e[41]) cval_q.push_back(resp_rd_data);
            end
            last_resp_cyc = cyc;
        end
    end

    // Driver: called at a negedge; returns at the negedge after acceptance
    // with the request still driven.
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] f3,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_data,
                         input logic [7:0] e_lat, input logic e_cnt, input logic push,
                         input logic b2b);
        int n = 0;
        if (push) exp_q.push_back({e_cnt, e_err, e_lat, e_data});
        req_valid   = 1'b1;
        req_addr    = a;
        req_wr      = w;
        req_funct3  = f3;
        req_wr_data = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_ready expected=ready addr=%h", a);
        end
        if (b2b) chk("b2b_accept_cycle", 32'(cyc), 32'(last_resp_cyc + 1));
        acc_q.push_back(cyc + 1);
        cnt_q.push_back(run_cnt + 32'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
            exp_q.delete();
            acc_q.delete();
            cnt_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int snap;
        int n;
        rst = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'd0;
        req_wr = 1'b0;
        req_funct3 = 3'd0;
        req_wr_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rd_data", resp_rd_data, 32'd0);
        chk("rst_ram_wr_ena", {31'd0, ram_wr_ena}, 32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_ram_wr_data", ram_wr_data, 32'd0);
        chk("rst_leds", {24'd0, leds}, 32'd0);

        // Loads from word 0x80FF_7F01 at byte 0x10
        issue(32'h13, 0, FUNCT3_LB,  0, 0, 32'hFFFF_FF80, 3, 0, 1, 0);
        issue(32'h13, 0, FUNCT3_LBU, 0, 0, 32'h0000_0080, 3, 0, 1, 0);
        issue(32'h12, 0, FUNCT3_LH,  0, 0, 32'hFFFF_80FF, 3, 0, 1, 0);
        issue(32'h12, 0, FUNCT3_LHU, 0, 0, 32'h0000_80FF, 3, 0, 1, 0);
        issue(32'h10, 0, FUNCT3_LW,  0, 0, 32'h80FF_7F01, 3, 0, 1, 0);
        issue(32'h11, 0, FUNCT3_LB,  0, 0, 32'h0000_007F, 3, 0, 1, 0);
        issue(32'h10, 0, FUNCT3_LH,  0, 0, 32'h0000_7F01, 3, 0, 1, 0);
        drain();

        // Sub-word stores via read-modify-write
        snap = wr_cnt;
        issue(32'h11, 1, FUNCT3_SB, 32'h0000_00AA, 0, 32'd0, 4, 0, 1, 0);
        drain();
        chk("sb_write_count", 32'(wr_cnt - snap), 32'd1);
        chk("sb_write_addr", {24'd0, last_wr_addr}, 32'd4);
        chk("sb_write_data", last_wr_data, 32'h80FF_AA01);
        issue(32'h10, 0, FUNCT3_LW, 0, 0, 32'h80FF_AA01, 3, 0, 1, 0);
        issue(32'h22, 1, FUNCT3_SH, 32'h5555_BEEF, 0, 32'd0, 4, 0, 1, 0);
        issue(32'h20, 0, FUNCT3_LW, 0, 0, 32'hBEEF_3344, 3, 0, 1, 0);
        issue(32'h24, 1, FUNCT3_SW, 32'hCAFE_F00D, 0, 32'd0, 2, 0, 1, 0);
        issue(32'h24, 0, FUNCT3_LW, 0, 0, 32'hCAFE_F00D, 3, 0, 1, 0);
        drain();

        // Errors: misaligned, unmapped, undefined funct3
        snap = wr_cnt;
        issue(32'h15,        1, FUNCT3_SW, 32'h1111_1111, 1, 32'd0, 1, 0, 1, 0);
        issue(32'h0000_1000, 0, FUNCT3_LW, 0,             1, 32'd0, 1, 0, 1, 0);
        issue(32'h11,        0, FUNCT3_LH, 0,             1, 32'd0, 1, 0, 1, 0);
        issue(32'h10,        0, 3'b011,    0,             1, 32'd0, 1, 0, 1, 0);
        issue(32'h10,        1, 3'b100,    32'h2222_2222, 1, 32'd0, 1, 0, 1, 0);
        issue(32'hFFFF_0008, 0, FUNCT3_LW, 0,             1, 32'd0, 1, 0, 1, 0);
        drain();
        chk("err_no_write", 32'(wr_cnt - snap), 32'd0);

        // MMIO
        issue(32'hFFFF_0000, 1, FUNCT3_SW, 32'h1234_5678, 0, 32'd0, 2, 0, 1, 0);
        drain();
        chk("led_value", {24'd0, leds}, 32'h0000_0078);
        issue(32'hFFFF_0000, 0, FUNCT3_LW, 0, 0, 32'h0000_0078, 2, 0, 1, 0);
        issue(32'hFFFF_0004, 1, FUNCT3_SW, 32'hDEAD_BEEF, 0, 32'd0, 2, 0, 1, 0);
        drain();
        issue(32'hFFFF_0004, 0, FUNCT3_LW, 0, 0, 32'd0, 2, 1, 1, 0);
        snap = cyc;
        req_valid = 1'b0;
        while (cyc < snap + 6) @(negedge clk);
        issue(32'hFFFF_0004, 0, FUNCT3_LW, 0, 0, 32'd0, 2, 1, 1, 0);
        drain();
        if (cval_q.size() == 2) chk("cycle_delta", cval_q[1] - cval_q[0], 32'd7);
        else chk("cycle_reads", 32'(cval_q.size()), 32'd2);

        // Reset in S_WAIT of SH aborts the request
        snap = wr_cnt;
        issue(32'h12, 1, FUNCT3_SH, 32'h0000_BEEF, 0, 32'd0, 4, 0, 0, 0);
        req_valid = 1'b0;
        n = 0;
        while (dbg_state != S_WAIT && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acc_q.delete();
        cnt_q.delete();
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_leds", {24'd0, leds}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_write", 32'(wr_cnt - snap), 32'd0);
        issue(32'h10, 0, FUNCT3_LW, 0, 0, 32'h80FF_AA01, 3, 0, 1, 0);
        drain();

        // Back-to-back with req_valid held high
        issue(32'h10, 0, FUNCT3_LW,  0, 0, 32'h80FF_AA01, 3, 0, 1, 0);
        issue(32'h13, 0, FUNCT3_LBU, 0, 0, 32'h0000_0080, 3, 0, 1, 1);
        issue(32'h20, 0, FUNCT3_LHU, 0, 0, 32'h0000_3344, 3, 0, 1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
